// File: rtl/decryption_scheduler.sv
// Front-end scheduler: routes one character stream to one of three decryption engines
// and muxes the selected engine's output back onto a single registered stream.
module decryption_scheduler #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
    parameter int                 START_TIMEOUT          = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [D_WIDTH-1:0]     data_i,
    input  logic                   valid_i,
    input  logic [1:0]             sel_i,
    output logic                   busy_o,
    output logic [D_WIDTH-1:0]     eng_data_o,
    output logic [2:0]             eng_valid_o,
    input  logic [2:0]             eng_busy_i,
    input  logic [3*D_WIDTH-1:0]   eng_data_i,
    input  logic [2:0]             eng_valid_i,
    output logic [D_WIDTH-1:0]     data_o,
    output logic                   valid_o,
    output logic                   err_o
);

    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_DISCARD,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_tmo;
    logic [D_WIDTH-1:0] r_eng_data;
    logic [2:0]         r_eng_valid;
    logic [D_WIDTH-1:0] r_data_o;
    logic               r_valid_o;
    logic               r_err;

    logic               w_tok;
    logic               w_eng_busy;
    logic               w_eng_valid;
    logic [D_WIDTH-1:0] w_eng_data;

    assign w_tok       = (data_i == START_DECRYPTION_TOKEN);
    assign w_eng_busy  = eng_busy_i[r_sel];
    assign w_eng_valid = eng_valid_i[r_sel];
    assign w_eng_data  = eng_data_i[r_sel*D_WIDTH +: D_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_eng_data  <= '0;
            r_eng_valid <= '0;
            r_data_o    <= '0;
            r_valid_o   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_eng_valid <= '0;
            r_err       <= 1'b0;
            // Output mux runs in every state so trailing engine output still passes.
            r_valid_o   <= w_eng_valid;
            r_data_o    <= w_eng_valid ? w_eng_data : '0;

            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (w_tok) begin
                            r_err <= 1'b1;
                        end else if (sel_i == 2'd3) begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end else begin
                            r_sel       <= sel_i;
                            r_eng_data  <= data_i;
                            r_eng_valid <= 3'b001 << sel_i;
                            r_cnt       <= CW'(1);
                            r_state     <= S_FWD;
                        end
                    end
                end
                S_FWD: begin
                    if (valid_i) begin
                        if (w_tok) begin
                            r_eng_data  <= data_i;
                            r_eng_valid <= 3'b001 << r_sel;
                            r_tmo       <= '0;
                            r_state     <= S_WAIT_START;
                        end else if (r_cnt == CW'(MAX_NOF_CHARS)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_eng_data  <= data_i;
                            r_eng_valid <= 3'b001 << r_sel;
                            r_cnt       <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (valid_i && w_tok) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_START: begin
                    if (valid_i) begin
                        r_err <= 1'b1;
                    end
                    if (w_eng_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_tmo == TW'(START_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (valid_i) begin
                        r_err <= 1'b1;
                    end
                    if (!w_eng_busy) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);
    assign eng_data_o  = r_eng_data;
    assign eng_valid_o = r_eng_valid;
    assign data_o      = r_data_o;
    assign valid_o     = r_valid_o;
    assign err_o       = r_err;

endmodule

// File: tb/tb_decryption_scheduler.sv
// Scoreboard bench for decryption_scheduler: stimulus pushes expected engine-side,
// output-side and error events; a negedge monitor pops and compares them.
module tb_decryption_scheduler;

    localparam logic [7:0] TOK  = 8'hFA;
    localparam int         MAXC = 50;
    localparam int         TMO  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic [1:0]  sel_i = '0;
    logic        busy_o;
    logic [7:0]  eng_data_o;
    logic [2:0]  eng_valid_o;
    logic [2:0]  eng_busy_i = '0;
    logic [23:0] eng_data_i = '0;
    logic [2:0]  eng_valid_i = '0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        err_o;

    int checks = 0;
    int passes = 0;

    logic [10:0] fwd_q[$];
    logic [7:0]  out_q[$];
    bit          err_q[$];

    decryption_scheduler #(
        .D_WIDTH(8),
        .MAX_NOF_CHARS(MAXC),
        .START_DECRYPTION_TOKEN(TOK),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_i(data_i),
        .valid_i(valid_i),
        .sel_i(sel_i),
        .busy_o(busy_o),
        .eng_data_o(eng_data_o),
        .eng_valid_o(eng_valid_o),
        .eng_busy_i(eng_busy_i),
        .eng_data_i(eng_data_i),
        .eng_valid_i(eng_valid_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_valid_o != 3'b000) begin
                if (fwd_q.size() == 0) check("fwd_unexpected", {21'd0, eng_valid_o, eng_data_o}, 32'd0);
                else check("fwd", {21'd0, eng_valid_o, eng_data_o}, {21'd0, fwd_q.pop_front()});
            end
            if (valid_o) begin
                if (out_q.size() == 0) check("out_unexpected", {23'd0, valid_o, data_o}, 32'd0);
                else check("out", {24'd0, data_o}, {24'd0, out_q.pop_front()});
            end else if (data_o != 8'h00) begin
                check("data_o_idle_zero", {24'd0, data_o}, 32'd0);
            end
            if (err_o) begin
                if (err_q.size() == 0) check("err_unexpected", {31'd0, err_o}, 32'd0);
                else void'(err_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        @(negedge clk);
        while (busy_o && c < 200) begin
            c++;
            @(negedge clk);
        end
        if (c >= 200) check("busy_release_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_eng_valid"}, {29'd0, eng_valid_o}, 32'd0);
        check({tag, "_eng_data"},  {24'd0, eng_data_o},  32'd0);
        check({tag, "_valid_o"},   {31'd0, valid_o},     32'd0);
        check({tag, "_data_o"},    {24'd0, data_o},      32'd0);
        check({tag, "_err_o"},     {31'd0, err_o},       32'd0);
        check({tag, "_busy_o"},    {31'd0, busy_o},      32'd0);
    endtask

    // mode 0: engine responds, 1: engine never busies (timeout), 2: reset during WAIT_DONE
    task automatic send_msg(input int sel, input int n, input int gap, input int mode, input int nout);
        logic [7:0] d;
        logic [2:0] oh;
        logic [2:0] gh;
        int         g;
        int         cyc;
        oh = (sel < 3) ? (3'b001 << sel) : 3'b000;
        g  = (sel + 1) % 3;
        gh = 3'b001 << g;
        for (int i = 0; i < n; i++) begin
            do d = 8'($urandom); while (d == TOK);
            valid_i = 1'b1;
            data_i  = d;
            sel_i   = (i == 0) ? 2'(sel) : 2'($urandom_range(0, 3));
            if (sel == 3) begin
                if (i == 0) err_q.push_back(1'b1);
            end else if (i < MAXC) fwd_q.push_back({oh, d});
            else err_q.push_back(1'b1);
            tick();
            valid_i = 1'b0;
            if (gap > 0) repeat ($urandom_range(0, gap)) tick();
        end
        valid_i = 1'b1;
        data_i  = TOK;
        sel_i   = 2'($urandom_range(0, 3));
        if (n == 0) err_q.push_back(1'b1);
        else if (sel != 3) fwd_q.push_back({oh, TOK});
        tick();
        valid_i = 1'b0;
        if (n == 0 || sel == 3) begin
            check("busy_after_nonmsg", {31'd0, busy_o}, 32'd0);
            return;
        end
        check("busy_after_token", {31'd0, busy_o}, 32'd1);
        if (mode == 1) begin
            err_q.push_back(1'b1);
            wait_idle(cyc);
            check("timeout_busy_cycles", cyc, TMO);
            return;
        end
        tick();
        eng_busy_i[sel] = 1'b1;
        tick();
        if (mode == 2) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            eng_busy_i = '0;
            check_all_zero("mid_reset");
            return;
        end
        do d = 8'($urandom); while (d == TOK);
        valid_i = 1'b1;
        data_i  = d;
        err_q.push_back(1'b1);
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < nout; k++) begin
            d = 8'($urandom);
            eng_valid_i = oh | gh;
            eng_data_i[sel*8 +: 8] = d;
            eng_data_i[g*8 +: 8]   = 8'($urandom);
            out_q.push_back(d);
            tick();
            eng_valid_i = '0;
        end
        check("busy_while_engine_busy", {31'd0, busy_o}, 32'd1);
        d = 8'($urandom);
        eng_busy_i  = '0;
        eng_valid_i = oh;
        eng_data_i[sel*8 +: 8] = d;
        out_q.push_back(d);
        tick();
        eng_valid_i = '0;
        wait_idle(cyc);
        check("busy_falls_with_engine", cyc, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        send_msg(2, 4, 0, 0, 2);
        send_msg(0, 3, 0, 0, 2);
        send_msg(3, 2, 0, 0, 0);
        send_msg(1, 51, 0, 0, 1);
        send_msg(2, 50, 0, 0, 1);
        send_msg(0, 2, 0, 1, 0);
        send_msg(0, 0, 0, 0, 0);
        send_msg(1, 3, 0, 2, 0);
        send_msg(0, 3, 0, 0, 2);

        for (int m = 0; m < 40; m++) begin
            send_msg($urandom_range(0, 3), $urandom_range(1, 8), 2,
                     ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 3));
        end

        repeat (5) tick();
        check("fwd_queue_drained", fwd_q.size(), 0);
        check("out_queue_drained", out_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
